// File: rtl/fifo_pkg.sv
// Shared types and helpers for the sync_fifo_flex FIFO family.
// Optional feature macro used by the slice: FIFO_PARITY_EN.
package fifo_pkg;

   // Read-port personality: registered read or first-word-fall-through.
   typedef enum logic {FIFO_STD, FIFO_FWFT} fifo_mode_e;

   // Widest word even_par accepts; narrower words are zero-extended,
   // which leaves the parity unchanged.
   localparam int unsigned PAR_MAX_W = 64;

   // Number of words for a given address width.
   function automatic int unsigned fifo_depth(input int unsigned addr_width);
      return 32'd1 << addr_width;
   endfunction

   // Even-parity bit: makes the total number of ones (data + bit) even.
   function automatic logic even_par(input logic [PAR_MAX_W-1:0] data);
      return ^data;
   endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: DEPTH x WIDTH register array, one synchronous write port and
// one asynchronous read port. Contents are deliberately not reset.
module fifo_mem
   import fifo_pkg::*;
#(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [WIDTH-1:0]      wr_data,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [WIDTH-1:0]      rd_data
);

   localparam int unsigned DEPTH = fifo_depth(ADDR_WIDTH);

   logic [WIDTH-1:0] mem [DEPTH];

   // Write port: store the word on the accepting edge.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_flex.sv
// Single-clock parametrised FIFO with standard or first-word-fall-through
// read mode, almost-full/almost-empty thresholds, occupancy/free counts and
// sticky overflow/underflow flags.
// Optional: define FIFO_PARITY_EN to store an even-parity bit per word and
// expose parity_err on the read side.
module sync_fifo_flex
   import fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 5,
   parameter int unsigned FWFT       = 0,
   parameter int unsigned AFULL_LVL  = (2 ** ADDR_WIDTH) - 4,
   parameter int unsigned AEMPTY_LVL = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  wr_en,
   input  logic                  rd_en,
   input  logic                  err_clr,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  FIFO_full,
   output logic                  FIFO_empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [ADDR_WIDTH:0]   count,
   output logic [ADDR_WIDTH:0]   avail,
`ifdef FIFO_PARITY_EN
   output logic                  parity_err,
`endif
   output logic                  overflow,
   output logic                  underflow
);

   localparam int unsigned DEPTH = fifo_depth(ADDR_WIDTH);
   localparam fifo_mode_e  MODE  = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

   localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] AFULL_C  = (ADDR_WIDTH + 1)'(AFULL_LVL);
   localparam logic [ADDR_WIDTH:0] AEMPTY_C = (ADDR_WIDTH + 1)'(AEMPTY_LVL);

`ifdef FIFO_PARITY_EN
   localparam int unsigned MEM_W = DATA_WIDTH + 1;
`else
   localparam int unsigned MEM_W = DATA_WIDTH;
`endif

   // Pointers carry one extra wrap bit above the memory index.
   logic [ADDR_WIDTH:0]   wptr_q, wptr_d;
   logic [ADDR_WIDTH:0]   rptr_q, rptr_d;
   logic [ADDR_WIDTH:0]   count_q, count_d;
   logic                  overflow_q, overflow_d;
   logic                  underflow_q, underflow_d;
   logic [DATA_WIDTH-1:0] dout_q, dout_d;

   logic                  full, empty;
   logic                  wa, ra;
   logic [MEM_W-1:0]      mem_wdata;
   logic [MEM_W-1:0]      mem_rdata;
   logic [DATA_WIDTH-1:0] rd_word;

`ifdef FIFO_PARITY_EN
   logic                  perr_q, perr_d;
   logic                  rd_perr;
`endif

   // Status flags, all derived from the registered occupancy.
   always_comb begin
      full         = (count_q == DEPTH_C);
      empty        = (count_q == '0);
      FIFO_full    = full;
      FIFO_empty   = empty;
      almost_full  = (count_q >= AFULL_C);
      almost_empty = (count_q <= AEMPTY_C);
      count        = count_q;
      avail        = DEPTH_C - count_q;
      overflow     = overflow_q;
      underflow    = underflow_q;
   end

   // Accept decisions; a read on a full FIFO frees the slot for a same-edge write.
   always_comb begin
      ra = rd_en && !empty;
      wa = wr_en && (!full || ra);
   end

   // Word written into memory, with parity appended when enabled.
   always_comb begin
`ifdef FIFO_PARITY_EN
      mem_wdata = {even_par(PAR_MAX_W'(data_in)), data_in};
`else
      mem_wdata = data_in;
`endif
   end

   fifo_mem #(
      .WIDTH      (MEM_W),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_mem (
      .clk     (clk),
      .wr_en   (wa),
      .wr_addr (wptr_q[ADDR_WIDTH-1:0]),
      .wr_data (mem_wdata),
      .rd_addr (rptr_q[ADDR_WIDTH-1:0]),
      .rd_data (mem_rdata)
   );

   // Split the head word into data and (optionally) its parity check result.
   always_comb begin
      rd_word = mem_rdata[DATA_WIDTH-1:0];
`ifdef FIFO_PARITY_EN
      rd_perr = mem_rdata[DATA_WIDTH] != even_par(PAR_MAX_W'(rd_word));
`endif
   end

   // Next-state: pointers, occupancy, sticky errors and registered read data.
   always_comb begin
      wptr_d      = wptr_q;
      rptr_d      = rptr_q;
      count_d     = count_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      dout_d      = dout_q;
`ifdef FIFO_PARITY_EN
      perr_d      = perr_q;
`endif

      if (wa) begin
         wptr_d = wptr_q + 1'b1;
      end
      if (ra) begin
         rptr_d = rptr_q + 1'b1;
         dout_d = rd_word;
`ifdef FIFO_PARITY_EN
         perr_d = rd_perr;
`endif
      end

      case ({wa, ra})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      // Clear first so a same-edge error still sets the flag.
      if (err_clr) begin
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end
      if (wr_en && !wa) begin
         overflow_d = 1'b1;
      end
      if (rd_en && !ra) begin
         underflow_d = 1'b1;
      end
   end

   // State registers; asynchronous active-low reset discards all stored words.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr_q      <= '0;
         rptr_q      <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
         dout_q      <= '0;
      end else begin
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
         dout_q      <= dout_d;
      end
   end

`ifdef FIFO_PARITY_EN
   // Registered parity result, used only in standard read mode.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perr_q <= 1'b0;
      end else begin
         perr_q <= perr_d;
      end
   end
`endif

   // Read-port personality: FWFT shows the head combinationally, zero when empty.
   always_comb begin
      if (MODE == FIFO_FWFT) begin
         data_out = empty ? '0 : rd_word;
`ifdef FIFO_PARITY_EN
         parity_err = !empty && rd_perr;
`endif
      end else begin
         data_out = dout_q;
`ifdef FIFO_PARITY_EN
         parity_err = perr_q;
`endif
      end
   end

   // Occupancy counter must track the pointer distance modulo 2*DEPTH.
   assert property (@(posedge clk) disable iff (!rst) count_q == (wptr_q - rptr_q));

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Directed and scoreboard tests for sync_fifo_flex in standard and FWFT modes.
// Honours FIFO_PARITY_EN when defined at compile time.
module tb_sync_fifo_flex;
   import fifo_pkg::*;

   logic clk;
   logic rst;

   // Standard-mode instance signals
   logic [7:0] s_din, s_dout;
   logic       s_wr, s_rd, s_clr;
   logic       s_full, s_empty, s_afull, s_aempty, s_ovf, s_unf;
   logic [5:0] s_count, s_avail;
   // FWFT-mode instance signals
   logic [7:0] f_din, f_dout;
   logic       f_wr, f_rd, f_clr;
   logic       f_full, f_empty, f_afull, f_aempty, f_ovf, f_unf;
   logic [5:0] f_count, f_avail;
`ifdef FIFO_PARITY_EN
   logic       s_perr, f_perr;
`endif

   int errors = 0;
   int checks = 0;

   sync_fifo_flex #(.FWFT(0)) u_std (
      .clk          (clk),
      .rst          (rst),
      .data_in      (s_din),
      .wr_en        (s_wr),
      .rd_en        (s_rd),
      .err_clr      (s_clr),
      .data_out     (s_dout),
      .FIFO_full    (s_full),
      .FIFO_empty   (s_empty),
      .almost_full  (s_afull),
      .almost_empty (s_aempty),
      .count        (s_count),
      .avail        (s_avail),
`ifdef FIFO_PARITY_EN
      .parity_err   (s_perr),
`endif
      .overflow     (s_ovf),
      .underflow    (s_unf)
   );

   sync_fifo_flex #(.FWFT(1)) u_fwft (
      .clk          (clk),
      .rst          (rst),
      .data_in      (f_din),
      .wr_en        (f_wr),
      .rd_en        (f_rd),
      .err_clr      (f_clr),
      .data_out     (f_dout),
      .FIFO_full    (f_full),
      .FIFO_empty   (f_empty),
      .almost_full  (f_afull),
      .almost_empty (f_aempty),
      .count        (f_count),
      .avail        (f_avail),
`ifdef FIFO_PARITY_EN
      .parity_err   (f_perr),
`endif
      .overflow     (f_ovf),
      .underflow    (f_unf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one edge and settle away from it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      checks++; if (s_count !== 6'd0)  begin errors++; $display("FAIL reset_count got %0d want 0", s_count); end
      checks++; if (s_avail !== 6'd32) begin errors++; $display("FAIL reset_avail got %0d want 32", s_avail); end
      checks++; if ({s_full, s_empty, s_afull, s_aempty} !== 4'b0101)
         begin errors++; $display("FAIL reset_flags got %b want 0101", {s_full, s_empty, s_afull, s_aempty}); end
      checks++; if ({s_ovf, s_unf} !== 2'b00) begin errors++; $display("FAIL reset_err got %b want 00", {s_ovf, s_unf}); end
      checks++; if (s_dout !== 8'h00) begin errors++; $display("FAIL reset_dout got %h want 00", s_dout); end
      checks++; if ({f_empty, f_count} !== {1'b1, 6'd0})
         begin errors++; $display("FAIL reset_fwft got %b/%0d want 1/0", f_empty, f_count); end
`ifdef FIFO_PARITY_EN
      checks++; if (s_perr !== 1'b0) begin errors++; $display("FAIL reset_perr got %b want 0", s_perr); end
`endif
   endtask

   task automatic test_fill_overflow();
      logic [5:0] exp_cnt;
      for (int i = 0; i < 37; i++) begin
         s_din = 8'(i); s_wr = 1'b1;
         tick();
         exp_cnt = (i + 1 > 32) ? 6'd32 : 6'(i + 1);
         checks++; if (s_count !== exp_cnt)
            begin errors++; $display("FAIL fill_count[%0d] got %0d want %0d", i, s_count, exp_cnt); end
         checks++; if (s_full !== (exp_cnt == 6'd32))
            begin errors++; $display("FAIL fill_full[%0d] got %b want %b", i, s_full, exp_cnt == 6'd32); end
         checks++; if (s_afull !== (exp_cnt >= 6'd28))
            begin errors++; $display("FAIL fill_afull[%0d] got %b want %b", i, s_afull, exp_cnt >= 6'd28); end
         checks++; if (s_ovf !== (i >= 32))
            begin errors++; $display("FAIL fill_ovf[%0d] got %b want %b", i, s_ovf, i >= 32); end
      end
      s_wr = 1'b0;
      for (int k = 0; k < 32; k++) begin
         checks++; if (u_std.u_mem.mem[k][7:0] !== 8'(k))
            begin errors++; $display("FAIL fill_mem[%0d] got %h want %h", k, u_std.u_mem.mem[k][7:0], 8'(k)); end
      end
      checks++; if (s_avail !== 6'd0) begin errors++; $display("FAIL fill_avail got %0d want 0", s_avail); end
   endtask

   task automatic test_drain_underflow();
      logic [5:0] exp_cnt;
      logic [7:0] exp_dat;
      for (int i = 0; i < 37; i++) begin
         s_rd = 1'b1;
         tick();
         exp_cnt = (i >= 31) ? 6'd0 : 6'(31 - i);
         exp_dat = (i < 32) ? 8'(i) : 8'h1F;
         checks++; if (s_dout !== exp_dat)
            begin errors++; $display("FAIL drain_dout[%0d] got %h want %h", i, s_dout, exp_dat); end
         checks++; if (s_count !== exp_cnt)
            begin errors++; $display("FAIL drain_count[%0d] got %0d want %0d", i, s_count, exp_cnt); end
         checks++; if (s_empty !== (exp_cnt == 6'd0))
            begin errors++; $display("FAIL drain_empty[%0d] got %b want %b", i, s_empty, exp_cnt == 6'd0); end
         checks++; if (s_aempty !== (exp_cnt <= 6'd4))
            begin errors++; $display("FAIL drain_aempty[%0d] got %b want %b", i, s_aempty, exp_cnt <= 6'd4); end
         checks++; if (s_unf !== (i >= 32))
            begin errors++; $display("FAIL drain_unf[%0d] got %b want %b", i, s_unf, i >= 32); end
      end
      s_rd = 1'b0; s_clr = 1'b1;
      tick();
      s_clr = 1'b0;
      checks++; if ({s_ovf, s_unf} !== 2'b00)
         begin errors++; $display("FAIL errclr got %b want 00", {s_ovf, s_unf}); end
   endtask

   task automatic test_fwft();
      f_din = 8'hA5; f_wr = 1'b1;
      tick();
      f_wr = 1'b0;
      checks++; if (f_dout !== 8'hA5) begin errors++; $display("FAIL fwft_dout got %h want a5", f_dout); end
      checks++; if (f_empty !== 1'b0)  begin errors++; $display("FAIL fwft_nonempty got %b want 0", f_empty); end
      f_rd = 1'b1;
      tick();
      f_rd = 1'b0;
      checks++; if ({f_empty, f_count} !== {1'b1, 6'd0})
         begin errors++; $display("FAIL fwft_pop got %b/%0d want 1/0", f_empty, f_count); end
      checks++; if (f_unf !== 1'b0) begin errors++; $display("FAIL fwft_unf got %b want 0", f_unf); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp_dat;
      for (int i = 0; i < 32; i++) begin
         s_din = 8'h40 + 8'(i); s_wr = 1'b1;
         tick();
      end
      checks++; if (s_full !== 1'b1) begin errors++; $display("FAIL b2b_full got %b want 1", s_full); end
      for (int j = 0; j < 10; j++) begin
         s_din = 8'h60 + 8'(j); s_wr = 1'b1; s_rd = 1'b1;
         tick();
         checks++; if (s_count !== 6'd32)
            begin errors++; $display("FAIL b2b_count[%0d] got %0d want 32", j, s_count); end
         checks++; if (s_ovf !== 1'b0) begin errors++; $display("FAIL b2b_ovf[%0d] got %b want 0", j, s_ovf); end
         checks++; if (s_dout !== 8'h40 + 8'(j))
            begin errors++; $display("FAIL b2b_dout[%0d] got %h want %h", j, s_dout, 8'h40 + 8'(j)); end
      end
      s_wr = 1'b0;
      for (int k = 0; k < 32; k++) begin
         s_rd = 1'b1;
         tick();
         exp_dat = (k < 22) ? 8'h4A + 8'(k) : 8'h60 + 8'(k - 22);
         checks++; if (s_dout !== exp_dat)
            begin errors++; $display("FAIL b2b_order[%0d] got %h want %h", k, s_dout, exp_dat); end
      end
      // Empty FIFO: write wins, read is rejected and data_out holds.
      s_din = 8'h77; s_wr = 1'b1; s_rd = 1'b1;
      tick();
      s_wr = 1'b0; s_rd = 1'b0;
      checks++; if (s_count !== 6'd1) begin errors++; $display("FAIL b2b_empty_count got %0d want 1", s_count); end
      checks++; if ({s_ovf, s_unf} !== 2'b01)
         begin errors++; $display("FAIL b2b_empty_err got %b want 01", {s_ovf, s_unf}); end
      checks++; if (s_dout !== 8'h69) begin errors++; $display("FAIL b2b_hold got %h want 69", s_dout); end
      s_rd = 1'b1;
      tick();
      checks++; if (s_dout !== 8'h77) begin errors++; $display("FAIL b2b_last got %h want 77", s_dout); end
      // Clear and a new rejected read on the same edge: set wins.
      s_clr = 1'b1;
      tick();
      checks++; if (s_unf !== 1'b1) begin errors++; $display("FAIL clr_vs_set got %b want 1", s_unf); end
      s_rd = 1'b0;
      tick();
      s_clr = 1'b0;
      checks++; if (s_unf !== 1'b0) begin errors++; $display("FAIL clr_only got %b want 0", s_unf); end
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 20; i++) begin
         s_din = 8'h80 + 8'(i); s_wr = 1'b1;
         tick();
      end
      s_wr = 1'b0;
      checks++; if (s_count !== 6'd20) begin errors++; $display("FAIL ar_fill got %0d want 20", s_count); end
      #2;
      rst = 1'b0;
      #1;
      checks++; if (s_count !== 6'd0) begin errors++; $display("FAIL ar_count got %0d want 0", s_count); end
      checks++; if ({s_empty, s_avail} !== {1'b1, 6'd32})
         begin errors++; $display("FAIL ar_empty got %b/%0d want 1/32", s_empty, s_avail); end
      checks++; if (s_dout !== 8'h00) begin errors++; $display("FAIL ar_dout got %h want 00", s_dout); end
      @(negedge clk);
      rst = 1'b1;
      tick();
      s_din = 8'h3C; s_wr = 1'b1;
      tick();
      s_wr = 1'b0;
      checks++; if (u_std.u_mem.mem[0][7:0] !== 8'h3C)
         begin errors++; $display("FAIL ar_mem0 got %h want 3c", u_std.u_mem.mem[0][7:0]); end
      s_rd = 1'b1;
      tick();
      s_rd = 1'b0;
      checks++; if (s_dout !== 8'h3C) begin errors++; $display("FAIL ar_read got %h want 3c", s_dout); end
      checks++; if (s_empty !== 1'b1) begin errors++; $display("FAIL ar_drained got %b want 1", s_empty); end
   endtask

   task automatic test_random();
      logic [7:0] q[$];
      logic [7:0] exp_dat;
      logic       m_ra, m_wa;
      for (int c = 0; c < 320; c++) begin
         // First half leans on writes, second half on reads, to visit both ends.
         s_wr  = (c < 160) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
         s_rd  = (c < 160) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
         s_din = 8'($urandom);
         m_ra  = s_rd && (q.size() != 0);
         m_wa  = s_wr && ((q.size() != 32) || m_ra);
         exp_dat = 8'h00;
         if (m_ra) exp_dat = q.pop_front();
         if (m_wa) q.push_back(s_din);
         tick();
         if (m_ra) begin
            checks++; if (s_dout !== exp_dat)
               begin errors++; $display("FAIL rnd_dout[%0d] got %h want %h", c, s_dout, exp_dat); end
         end
         checks++; if (s_count !== 6'(q.size()))
            begin errors++; $display("FAIL rnd_count[%0d] got %0d want %0d", c, s_count, q.size()); end
      end
      s_wr = 1'b0; s_rd = 1'b0;
   endtask

`ifdef FIFO_PARITY_EN
   task automatic test_parity();
      logic [PAR_MAX_W-1:0] wide;
      rst = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      s_din = 8'h5A; s_wr = 1'b1;
      tick();
      s_din = 8'h33;
      tick();
      s_wr = 1'b0;
      wide = PAR_MAX_W'(8'h5A);
      checks++; if (u_std.u_mem.mem[0][8] !== even_par(wide))
         begin errors++; $display("FAIL par_stored got %b want %b", u_std.u_mem.mem[0][8], even_par(wide)); end
      u_std.u_mem.mem[0][0] = ~u_std.u_mem.mem[0][0];
      s_rd = 1'b1;
      tick();
      checks++; if ({s_perr, s_dout} !== {1'b1, 8'h5B})
         begin errors++; $display("FAIL par_flip got %b/%h want 1/5b", s_perr, s_dout); end
      tick();
      s_rd = 1'b0;
      checks++; if ({s_perr, s_dout} !== {1'b0, 8'h33})
         begin errors++; $display("FAIL par_clean got %b/%h want 0/33", s_perr, s_dout); end
   endtask
`endif

   initial begin
      rst = 1'b0;
      s_din = '0; s_wr = 1'b0; s_rd = 1'b0; s_clr = 1'b0;
      f_din = '0; f_wr = 1'b0; f_rd = 1'b0; f_clr = 1'b0;
      #3;
      test_reset();
      #9;
      rst = 1'b1;
      tick();
      test_reset();
      test_fill_overflow();
      test_drain_underflow();
      test_fwft();
      test_back_to_back();
      test_async_reset();
      test_random();
`ifdef FIFO_PARITY_EN
      test_parity();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
